riscv_data_req_buffer: RTL and testbench

Data-side request buffer between `riscv_load_store_unit` (upstream) and the data memory bus (downstream). It registers every granted LSU request into a one-entry slice before driving it onto the bus, which breaks the LSU-to-bus combinational path. It counts outstanding bus transactions, caps them, and passes responses back in order with zero added latency. An optional address-window check answers out-of-window requests locally with an error response, without issuing them on the bus.

---
 rtl/riscv_defines.sv | 26 ++
 rtl/riscv_data_req_buffer_chk.sv | 21 ++
 rtl/riscv_data_req_slice.sv | 28 ++
 rtl/riscv_data_req_buffer.sv | 139 +++++++++++++
 tb/tb_riscv_data_req_buffer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/riscv_defines.sv
// Shared types for the data-side request buffer.
// The ErrResp state exists only when RISCV_DATA_ADDR_CHECK_EN is defined.
package riscv_defines;

`ifdef RISCV_DATA_ADDR_CHECK_EN
  typedef enum logic [1:0] {
    Idle    = 2'd0,
    Fwd     = 2'd1,
    ErrResp = 2'd2
  } data_buf_state_e;
`else
  typedef enum logic [1:0] {
    Idle = 2'd0,
    Fwd  = 2'd1
  } data_buf_state_e;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [5:0]  atop;
  } data_req_t;

endpackage

// File: rtl/riscv_data_req_buffer_chk.sv
// Protocol checks for riscv_data_req_buffer: orphan bus responses and
// an empty address window.
module riscv_data_req_buffer_chk #(
  parameter int unsigned CW      = 2,
  parameter logic [31:0] ADDR_LO = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI = 32'hFFFF_FFFF
) (
  input logic          clk_i,
  input logic          rst_i,
  input logic          bus_rvalid_i,
  input logic [CW-1:0] cnt_q
);

  a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus_rvalid_i && (cnt_q == '0)))
    else $error("bus response with no outstanding transaction");

  a_window_nonempty: assert property (@(posedge clk_i) ADDR_LO <= ADDR_HI)
    else $error("address window is empty");

endmodule

// File: rtl/riscv_data_req_slice.sv
// One-entry valid/ready register holding a data request; contents hold
// while the entry waits for the downstream side to accept it.
module riscv_data_req_slice
  import riscv_defines::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      in_valid,
  input  data_req_t in_data,
  input  logic      out_ready,
  output logic      out_valid,
  output data_req_t out_data
);

  // load on a new request, otherwise drop the entry once it is accepted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/riscv_data_req_buffer.sv
// Registered LSU-to-bus request buffer with outstanding-transaction cap.
// Define RISCV_DATA_ADDR_CHECK_EN to answer out-of-window requests locally.
module riscv_data_req_buffer
  import riscv_defines::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] ADDR_LO         = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI         = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  output logic        lsu_gnt_o,
  input  logic [31:0] lsu_addr_i,
  input  logic        lsu_we_i,
  input  logic [3:0]  lsu_be_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [5:0]  lsu_atop_i,
  output logic        lsu_rvalid_o,
  output logic        lsu_err_o,
  output logic [31:0] lsu_rdata_o,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  output logic [5:0]  bus_atop_o,
  input  logic        bus_rvalid_i,
  input  logic        bus_err_i,
  input  logic [31:0] bus_rdata_i,
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  data_buf_state_e state_q;
  logic [CW-1:0]   cnt_q;
  logic            fwd;
  logic [CW:0]     load;
  logic            room;
  logic            slot;
  logic            oow;
  logic            gnt;
  logic            rsp_ok;
  logic            err_rsp;
  logic            slice_valid;
  data_req_t       req_in;
  data_req_t       req_out;

  assign fwd    = (state_q == Fwd);
  assign load   = {1'b0, cnt_q} + {{CW{1'b0}}, fwd};
  // a response in this cycle frees a slot, so it may unblock the cap
  assign room   = (load < (CW+1)'(MAX_OUTSTANDING)) || bus_rvalid_i;
  assign slot   = (state_q == Idle) || (fwd && bus_gnt_i);
  assign rsp_ok = bus_rvalid_i && (cnt_q != '0);

`ifdef RISCV_DATA_ADDR_CHECK_EN
  assign oow     = (lsu_addr_i < ADDR_LO) || (lsu_addr_i > ADDR_HI);
  assign err_rsp = (state_q == ErrResp);
  assign gnt     = lsu_req_i && slot && room &&
                   (!oow || ((state_q == Idle) && (cnt_q == '0)));
`else
  assign oow     = 1'b0;
  assign err_rsp = 1'b0;
  assign gnt     = lsu_req_i && slot && room;
`endif

  assign req_in = '{addr: lsu_addr_i, we: lsu_we_i, be: lsu_be_i,
                    wdata: lsu_wdata_i, atop: lsu_atop_i};

  riscv_data_req_slice u_slice (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_valid  (gnt && !oow),
    .in_data   (req_in),
    .out_ready (bus_gnt_i),
    .out_valid (slice_valid),
    .out_data  (req_out)
  );

  // request FSM and outstanding-transaction counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Idle;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        Idle: begin
          if (gnt) begin
`ifdef RISCV_DATA_ADDR_CHECK_EN
            state_q <= oow ? ErrResp : Fwd;
`else
            state_q <= Fwd;
`endif
          end
        end
        Fwd: begin
          if (bus_gnt_i) begin
            state_q <= gnt ? Fwd : Idle;
          end
        end
`ifdef RISCV_DATA_ADDR_CHECK_EN
        ErrResp: state_q <= Idle;
`endif
        default: state_q <= Idle;
      endcase
      case ({fwd && bus_gnt_i, rsp_ok})
        2'b10:   cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign lsu_gnt_o    = gnt;
  assign bus_req_o    = fwd;
  assign bus_addr_o   = req_out.addr;
  assign bus_we_o     = req_out.we;
  assign bus_be_o     = req_out.be;
  assign bus_wdata_o  = req_out.wdata;
  assign bus_atop_o   = req_out.atop;
  assign lsu_rvalid_o = err_rsp || rsp_ok;
  assign lsu_err_o    = err_rsp || bus_err_i;
  assign lsu_rdata_o  = err_rsp ? 32'h0000_0000 : bus_rdata_i;
  assign busy_o       = slice_valid || (cnt_q != '0) || err_rsp;

  riscv_data_req_buffer_chk #(
    .CW      (CW),
    .ADDR_LO (ADDR_LO),
    .ADDR_HI (ADDR_HI)
  ) u_chk (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bus_rvalid_i (bus_rvalid_i),
    .cnt_q        (cnt_q)
  );

endmodule

// File: tb/tb_riscv_data_req_buffer.sv
// Directed bench for riscv_data_req_buffer with a response scoreboard.
module tb_riscv_data_req_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsu_req = 1'b0;
  logic        lsu_gnt;
  logic [31:0] lsu_addr = 32'h0;
  logic        lsu_we = 1'b0;
  logic [3:0]  lsu_be = 4'h0;
  logic [31:0] lsu_wdata = 32'h0;
  logic [5:0]  lsu_atop = 6'h0;
  logic        lsu_rvalid;
  logic        lsu_err;
  logic [31:0] lsu_rdata;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [5:0]  bus_atop;
  logic        bus_rvalid = 1'b0;
  logic        bus_err = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        busy;

  int total = 0;
  int bad = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  riscv_data_req_buffer #(
    .MAX_OUTSTANDING (2),
    .ADDR_LO         (32'h0000_0000),
`ifdef RISCV_DATA_ADDR_CHECK_EN
    .ADDR_HI         (32'h0000_0FFF)
`else
    .ADDR_HI         (32'hFFFF_FFFF)
`endif
  ) dut (
    .clk_i (clk), .rst_i (rst),
    .lsu_req_i (lsu_req), .lsu_gnt_o (lsu_gnt), .lsu_addr_i (lsu_addr),
    .lsu_we_i (lsu_we), .lsu_be_i (lsu_be), .lsu_wdata_i (lsu_wdata),
    .lsu_atop_i (lsu_atop), .lsu_rvalid_o (lsu_rvalid), .lsu_err_o (lsu_err),
    .lsu_rdata_o (lsu_rdata), .bus_req_o (bus_req), .bus_gnt_i (bus_gnt),
    .bus_addr_o (bus_addr), .bus_we_o (bus_we), .bus_be_o (bus_be),
    .bus_wdata_o (bus_wdata), .bus_atop_o (bus_atop),
    .bus_rvalid_i (bus_rvalid), .bus_err_i (bus_err),
    .bus_rdata_i (bus_rdata), .busy_o (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // compare the response port against the scoreboard head
  task automatic resp(input string tag, input logic exp_valid);
    logic [32:0] e;
    chk({tag, "_rvalid"}, {31'h0, lsu_rvalid}, {31'h0, exp_valid});
    if (lsu_rvalid) begin
      chk({tag, "_sb_nonempty"}, {31'h0, exp_q.size() != 0}, 32'h1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk({tag, "_err"}, {31'h0, lsu_err}, {31'h0, e[32]});
        chk({tag, "_rdata"}, lsu_rdata, e[31:0]);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    cyc();
    @(negedge clk);
    chk("rst_gnt", {31'h0, lsu_gnt}, 32'h0);
    chk("rst_busreq", {31'h0, bus_req}, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    resp("rst", 1'b0);
    cyc(); rst = 1'b0;

    // single load
    cyc(); lsu_req = 1'b1; lsu_addr = 32'h100; lsu_we = 1'b0; lsu_be = 4'hF;
    @(negedge clk);
    chk("ld_gnt", {31'h0, lsu_gnt}, 32'h1);
    chk("ld_busreq0", {31'h0, bus_req}, 32'h0);
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    cyc(); lsu_req = 1'b0; bus_gnt = 1'b1;
    @(negedge clk);
    chk("ld_busreq1", {31'h0, bus_req}, 32'h1);
    chk("ld_addr", bus_addr, 32'h100);
    chk("ld_we", {31'h0, bus_we}, 32'h0);
    chk("ld_busy", {31'h0, busy}, 32'h1);
    cyc(); bus_gnt = 1'b0;
    @(negedge clk);
    chk("ld_busreq2", {31'h0, bus_req}, 32'h0);
    chk("ld_cnt2", 32'(dut.cnt_q), 32'h1);
    cyc(); bus_rvalid = 1'b1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    resp("ld_rsp", 1'b1);
    chk("ld_cnt3", 32'(dut.cnt_q), 32'h1);
    cyc(); bus_rvalid = 1'b0;
    @(negedge clk);
    chk("ld_cnt4", 32'(dut.cnt_q), 32'h0);
    chk("ld_busy4", {31'h0, busy}, 32'h0);
    resp("ld_idle", 1'b0);

    // store with bus stall, second request blocked meanwhile
    cyc(); lsu_req = 1'b1; lsu_addr = 32'h200; lsu_we = 1'b1; lsu_wdata = 32'h12345678;
    @(negedge clk);
    chk("st_gnt", {31'h0, lsu_gnt}, 32'h1);
    exp_q.push_back({1'b0, 32'h11111111});
    for (int i = 0; i < 4; i++) begin
      cyc(); lsu_addr = 32'h204; lsu_wdata = 32'hAAAA5555;
      @(negedge clk);
      chk("stall_gnt", {31'h0, lsu_gnt}, 32'h0);
      chk("stall_req", {31'h0, bus_req}, 32'h1);
      chk("stall_wdata", bus_wdata, 32'h12345678);
      chk("stall_addr", bus_addr, 32'h200);
    end
    cyc(); bus_gnt = 1'b1;
    @(negedge clk);
    chk("b2b_gnt", {31'h0, lsu_gnt}, 32'h1);
    exp_q.push_back({1'b0, 32'h22222222});
    cyc(); lsu_req = 1'b0;
    @(negedge clk);
    chk("b2b_req", {31'h0, bus_req}, 32'h1);
    chk("b2b_addr", bus_addr, 32'h204);
    chk("b2b_wdata", bus_wdata, 32'hAAAA5555);
    chk("b2b_cnt", 32'(dut.cnt_q), 32'h1);
    cyc(); bus_gnt = 1'b0;
    @(negedge clk);
    chk("full_req", {31'h0, bus_req}, 32'h0);
    chk("full_cnt", 32'(dut.cnt_q), 32'h2);

    // limit reached, then a response frees a slot in the same cycle
    cyc(); lsu_req = 1'b1; lsu_addr = 32'h300; lsu_we = 1'b0;
    @(negedge clk);
    chk("lim_gnt0", {31'h0, lsu_gnt}, 32'h0);
    cyc(); bus_rvalid = 1'b1; bus_rdata = 32'h11111111;
    @(negedge clk);
    chk("lim_gnt1", {31'h0, lsu_gnt}, 32'h1);
    exp_q.push_back({1'b1, 32'h33333333});
    resp("lim_rsp1", 1'b1);
    cyc(); lsu_req = 1'b0; bus_gnt = 1'b1; bus_rdata = 32'h22222222;
    @(negedge clk);
    chk("lim_addr", bus_addr, 32'h300);
    resp("lim_rsp2", 1'b1);
    chk("lim_cnt", 32'(dut.cnt_q), 32'h1);
    cyc(); bus_gnt = 1'b0; bus_err = 1'b1; bus_rdata = 32'h33333333;
    @(negedge clk);
    resp("err_rsp", 1'b1);
    chk("err_flag", {31'h0, lsu_err}, 32'h1);
    cyc(); bus_rvalid = 1'b0; bus_err = 1'b0;
    @(negedge clk);
    chk("drain_cnt", 32'(dut.cnt_q), 32'h0);
    chk("drain_busy", {31'h0, busy}, 32'h0);
    resp("drain", 1'b0);

    // reset with one outstanding and the slice full
    cyc(); lsu_req = 1'b1; lsu_addr = 32'h400;
    @(negedge clk);
    chk("mr_gnt0", {31'h0, lsu_gnt}, 32'h1);
    cyc(); lsu_addr = 32'h404; bus_gnt = 1'b1;
    @(negedge clk);
    chk("mr_gnt1", {31'h0, lsu_gnt}, 32'h1);
    cyc(); lsu_req = 1'b0; bus_gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mr_cnt", 32'(dut.cnt_q), 32'h1);
    chk("mr_req_pre", {31'h0, bus_req}, 32'h1);
    cyc(); bus_rvalid = 1'b1; bus_rdata = 32'h55;
    @(negedge clk);
    chk("mr_req", {31'h0, bus_req}, 32'h0);
    chk("mr_cnt0", 32'(dut.cnt_q), 32'h0);
    chk("mr_addr", bus_addr, 32'h0);
    resp("mr_drop", 1'b0);
    cyc(); rst = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    chk("mr_busy", {31'h0, busy}, 32'h0);
    chk("mr_req2", {31'h0, bus_req}, 32'h0);

`ifdef RISCV_DATA_ADDR_CHECK_EN
    // out-of-window request answered locally
    cyc(); lsu_req = 1'b1; lsu_addr = 32'h2000;
    @(negedge clk);
    chk("oow_gnt", {31'h0, lsu_gnt}, 32'h1);
    exp_q.push_back({1'b1, 32'h0});
    cyc(); lsu_addr = 32'h100;
    @(negedge clk);
    chk("oow_busreq", {31'h0, bus_req}, 32'h0);
    chk("oow_nogrant", {31'h0, lsu_gnt}, 32'h0);
    resp("oow_rsp", 1'b1);
    cyc(); lsu_req = 1'b0;
    @(negedge clk);
    chk("oow_busreq2", {31'h0, bus_req}, 32'h0);
    resp("oow_idle", 1'b0);
`endif

    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
